bias_mode_scheduler: RTL
========================

# bias_mode_scheduler

Sequences and shares the panel bias MUX controller among several requesters: the readout sequencer, the host register interface and the power manager, plus an internal idle/sleep auto-timer. It arbitrates bias-mode requests by fixed priority, drives `bias_mode_select` and tracks the controller's `bias_busy`/`bias_ready` handshake to completion. It also applies a settle watchdog and reports completion per requester. It sits between the control-plane requesters and the bias MUX controller.

## Interface
- `IDLE_TIMEOUT`, default 100_000: inactivity cycles (1 ms at 100 MHz) before an auto request to IDLE_LOW.
- `SLEEP_TIMEOUT`, default 10_000_000: inactivity cycles before an auto request to SLEEP; must exceed `IDLE_TIMEOUT`.
- `SETTLE_TIMEOUT`, default 4096: watchdog cycles allowed for one bias transition.
- `TIMER_W`, default 32: width of the inactivity timer.
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  3  per-requester request: bit0 readout sequencer, bit1 host, bit2 power manager.
- `req_mode`  in  6  requested mode, 2 bits per requester; `[2i+1:2i]` belongs to requester i.
- `req_ready`  out  3  one-hot, one-cycle acceptance pulse.
- `activity`  in  1  readout activity pulse; clears the inactivity timer.
- `auto_en`  in  1  enables auto IDLE_LOW/SLEEP requests.
- `bias_mode_select`  out  2  mode driven to the bias MUX controller.
- `bias_busy`  in  1  controller is switching.
- `bias_ready`  in  1  controller is settled.
- `cur_mode`  out  2  last mode confirmed settled.
- `done`  out  1  one-cycle pulse when an accepted request completes.
- `done_id`  out  2  requester of the completed request; 3 means auto.
- `err`  out  2  sticky flags: bit0 settle timeout, bit1 invalid mode (2'b11) requested.
- `clr_err`  in  1  clears `err`.

## Operation
- Modes: NORMAL=0, IDLE_LOW=1, SLEEP=2. Mode 3 is reserved.
- FSM states: STABLE, WAIT_BUSY, WAIT_DONE.
- Arbitration happens only in STABLE with `bias_ready`=1 and `bias_busy`=0.
  - Priority order: req0 > req1 > req2 > auto.
  - Requesters hold `req_valid` and `req_mode` stable until `req_ready`. Requests made outside STABLE wait.
- Accepting a request with mode 3: `req_ready` pulses, `err[1]` sets, no transition occurs and `done` does not pulse.
- Accepting a request whose mode equals `cur_mode`: `req_ready` and `done` pulse together, and the FSM stays in STABLE.
- Accepting any other request:
  - load `bias_mode_select`, latch the requester id and clear the watchdog;
  - go to WAIT_BUSY.
- WAIT_BUSY: when `bias_busy`=1, go to WAIT_DONE.
- WAIT_DONE: when `bias_ready`=1 and `bias_busy`=0:
  - `cur_mode` takes `bias_mode_select`;
  - `done` pulses with `done_id`;
  - go to STABLE.
- Watchdog: counts in WAIT_BUSY and WAIT_DONE. On reaching `SETTLE_TIMEOUT`-1:
  - set `err[0]` and go to STABLE;
  - leave `cur_mode` unchanged; `done` does not pulse.
- Inactivity timer:
  - counts every cycle while `auto_en`=1 and `activity`=0, saturating at all-ones;
  - cleared by `activity` or by `auto_en`=0.
- Auto request IDLE_LOW: raised when timer ≥ `IDLE_TIMEOUT`-1 and `cur_mode`=NORMAL.
- Auto request SLEEP: raised when timer ≥ `SLEEP_TIMEOUT`-1 and `cur_mode`=IDLE_LOW.
- Auto requests only move toward lower power; wake-up is always an explicit request.
- `clr_err` and a new error in the same cycle: the error wins.

## Timing
- Reset values: `bias_mode_select`=0, `cur_mode`=0, `req_ready`=0, `done`=0, `done_id`=0, `err`=0, state STABLE, timer 0, watchdog 0.
- All outputs are registered.
- Acceptance: `req_ready` and the new `bias_mode_select` appear after the same edge.
- `done` asserts on the edge after `bias_ready`=1 and `bias_busy`=0 is sampled in WAIT_DONE.
- Minimum STABLE-to-STABLE latency equals the controller switch time plus 2 cycles.
- Activity clears the timer on the next edge. An auto request already raised is withdrawn on that edge if not yet accepted.
- Reset mid-transition clears everything asynchronously. `bias_mode_select` returns to NORMAL.

## Structure
- Shared package `bias_pkg`:
  - `bias_mode_t` enum;
  - `bias_sched_state_t` enum;
  - constant `AUTO_ID`=2'd3.
- Sub-module `bias_idle_timer`: holds the inactivity counter and the auto-request generator. Its inputs are `activity`, `auto_en` and `cur_mode`; its outputs are `auto_valid` and `auto_mode`.

## Test plan
- After reset, req1=SLEEP; the controller model raises busy for 1000 cycles → `req_ready`=3'b010 and `bias_mode_select`=2, then `done` with `done_id`=1 and `cur_mode`=2.
- req0=NORMAL and req2=SLEEP asserted in the same cycle → req0 served first; req2 accepted only after req0's `done`.
- req1=NORMAL while `cur_mode`=NORMAL → `req_ready` and `done` pulse together, and `bias_mode_select` does not toggle.
- Controller model never raises `bias_busy` → `err[0]`=1 after 4096 cycles, FSM back in STABLE, `cur_mode` unchanged; `clr_err` clears it.
- `auto_en`=1 with no activity, `IDLE_TIMEOUT`=100 and `SLEEP_TIMEOUT`=300:
  - transition to IDLE_LOW with `done_id`=3, then to SLEEP;
  - an `activity` pulse at cycle 50 restarts the count.
- Mode 3 requested → `err[1]` set and no transition. Separately, `rst_n` low during WAIT_DONE → all outputs return to reset values immediately.

Source files
------------

// File: rtl/bias_pkg.sv
// -----------------------------------------------------------------------------
// bias_pkg
// Shared types and constants for the bias-mode scheduler and its sub-blocks.
//   bias_mode_t        : bias MUX modes (NORMAL, IDLE_LOW, SLEEP, reserved)
//   bias_sched_state_t : scheduler FSM states
//   AUTO_ID            : done_id reported for requests raised by the idle timer
//   NUM_REQ            : number of external requesters
// -----------------------------------------------------------------------------
package bias_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL   = 2'd0,
    MODE_IDLE_LOW = 2'd1,
    MODE_SLEEP    = 2'd2,
    MODE_RSVD     = 2'd3
  } bias_mode_t;

  typedef enum logic [1:0] {
    ST_STABLE    = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } bias_sched_state_t;

  localparam logic [1:0] AUTO_ID = 2'd3;
  localparam int         NUM_REQ = 3;

endpackage

// File: rtl/bias_idle_timer.sv
// -----------------------------------------------------------------------------
// bias_idle_timer
// Inactivity counter plus the automatic low-power request generator.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   activity    : readout activity pulse, restarts the count
//   auto_en     : enables counting; when low the count is held at zero
//   cur_mode    : last settled bias mode
//   auto_valid  : automatic request pending
//   auto_mode   : mode requested automatically (IDLE_LOW or SLEEP)
// -----------------------------------------------------------------------------
module bias_idle_timer
  import bias_pkg::*;
#(
  parameter int IDLE_TIMEOUT  = 100_000,
  parameter int SLEEP_TIMEOUT = 10_000_000,
  parameter int TIMER_W       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       activity,
  input  logic       auto_en,
  input  logic [1:0] cur_mode,
  output logic       auto_valid,
  output logic [1:0] auto_mode
);

  localparam logic [TIMER_W-1:0] IDLE_THR  = TIMER_W'(IDLE_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] SLEEP_THR = TIMER_W'(SLEEP_TIMEOUT - 1);

  logic [TIMER_W-1:0] timer_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_reg <= '0;
    end else if (activity || !auto_en) begin
      timer_reg <= '0;
    end else if (timer_reg != '1) begin
      timer_reg <= timer_reg + 1'b1;
    end
  end

  // Decoded straight from the counter, so a clear by activity withdraws a
  // pending request on the same edge that zeroes the count. Requests only
  // ever step one level down in power; wake-up is left to explicit requesters.
  always_comb begin
    auto_valid = 1'b0;
    auto_mode  = MODE_NORMAL;
    if (cur_mode == MODE_NORMAL && timer_reg >= IDLE_THR) begin
      auto_valid = 1'b1;
      auto_mode  = MODE_IDLE_LOW;
    end else if (cur_mode == MODE_IDLE_LOW && timer_reg >= SLEEP_THR) begin
      auto_valid = 1'b1;
      auto_mode  = MODE_SLEEP;
    end
  end

endmodule

// File: rtl/bias_mode_scheduler.sv
// -----------------------------------------------------------------------------
// bias_mode_scheduler
// Arbitrates bias-mode requests from three requesters and the idle timer,
// drives the bias MUX controller and tracks its busy/ready handshake.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid[2:0]    : requests (0 readout seq, 1 host, 2 power manager)
//   req_mode[5:0]     : 2-bit mode per requester, [2i+1:2i] for requester i
//   req_ready[2:0]    : one-hot one-cycle acceptance pulse
//   activity, auto_en : idle timer control
//   bias_mode_select  : mode driven to the controller
//   bias_busy         : controller switching
//   bias_ready        : controller settled
//   cur_mode          : last mode confirmed settled
//   done, done_id     : completion pulse and requester (3 = auto)
//   err[1:0]          : sticky: bit0 settle timeout, bit1 reserved mode
//   clr_err           : clears err (a new error in the same cycle wins)
// -----------------------------------------------------------------------------
module bias_mode_scheduler
  import bias_pkg::*;
#(
  parameter int IDLE_TIMEOUT   = 100_000,
  parameter int SLEEP_TIMEOUT  = 10_000_000,
  parameter int SETTLE_TIMEOUT = 4096,
  parameter int TIMER_W        = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req_valid,
  input  logic [5:0] req_mode,
  output logic [2:0] req_ready,
  input  logic       activity,
  input  logic       auto_en,
  output logic [1:0] bias_mode_select,
  input  logic       bias_busy,
  input  logic       bias_ready,
  output logic [1:0] cur_mode,
  output logic       done,
  output logic [1:0] done_id,
  output logic [1:0] err,
  input  logic       clr_err
);

  localparam int              WD_W    = $clog2(SETTLE_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(SETTLE_TIMEOUT - 1);

  bias_sched_state_t state_reg, state_next;
  logic [1:0]        sel_reg, sel_next;
  logic [1:0]        cur_reg, cur_next;
  logic [2:0]        ready_reg, ready_next;
  logic              done_reg, done_next;
  logic [1:0]        done_id_reg, done_id_next;
  logic [1:0]        err_reg, err_next;
  logic [1:0]        id_reg, id_next;
  logic [WD_W-1:0]   wdog_reg, wdog_next;

  logic              auto_valid;
  logic [1:0]        auto_mode;

  bias_idle_timer #(
    .IDLE_TIMEOUT  (IDLE_TIMEOUT),
    .SLEEP_TIMEOUT (SLEEP_TIMEOUT),
    .TIMER_W       (TIMER_W)
  ) u_idle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .activity   (activity),
    .auto_en    (auto_en),
    .cur_mode   (cur_reg),
    .auto_valid (auto_valid),
    .auto_mode  (auto_mode)
  );

  // A requester only sees req_ready one cycle after acceptance, so its valid
  // is still up in that cycle; masking it prevents a double acceptance when
  // the FSM is still in STABLE (same-mode or reserved-mode requests).
  logic [2:0] req_eff;
  assign req_eff = req_valid & ~ready_reg;

  logic       grant_valid;
  logic [1:0] grant_id;
  logic [1:0] grant_mode;

  // Fixed priority: scanning from the lowest priority upward lets the
  // highest-priority active requester overwrite the others.
  always_comb begin
    grant_valid = auto_valid;
    grant_id    = AUTO_ID;
    grant_mode  = auto_mode;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_eff[i]) begin
        grant_valid = 1'b1;
        grant_id    = 2'(i);
        grant_mode  = req_mode[2*i +: 2];
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    cur_next     = cur_reg;
    ready_next   = '0;
    done_next    = 1'b0;
    done_id_next = done_id_reg;
    id_next      = id_reg;
    wdog_next    = wdog_reg;
    err_next     = clr_err ? 2'b00 : err_reg;

    unique case (state_reg)
      ST_STABLE: begin
        if (bias_ready && !bias_busy && grant_valid) begin
          if (grant_id != AUTO_ID) begin
            ready_next = 3'b001 << grant_id;
          end
          if (grant_mode == MODE_RSVD) begin
            err_next[1] = 1'b1;
          end else if (grant_mode == cur_reg) begin
            done_next    = 1'b1;
            done_id_next = grant_id;
          end else begin
            sel_next   = grant_mode;
            id_next    = grant_id;
            wdog_next  = '0;
            state_next = ST_WAIT_BUSY;
          end
        end
      end

      ST_WAIT_BUSY, ST_WAIT_DONE: begin
        wdog_next = wdog_reg + 1'b1;
        // Timeout abandons the transition: cur_mode keeps the last settled
        // mode and no completion is reported.
        if (wdog_reg == WD_LAST) begin
          err_next[0] = 1'b1;
          wdog_next   = '0;
          state_next  = ST_STABLE;
        end else if (state_reg == ST_WAIT_BUSY) begin
          if (bias_busy) begin
            state_next = ST_WAIT_DONE;
          end
        end else if (bias_ready && !bias_busy) begin
          cur_next     = sel_reg;
          done_next    = 1'b1;
          done_id_next = id_reg;
          state_next   = ST_STABLE;
        end
      end

      default: state_next = ST_STABLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_STABLE;
      sel_reg     <= MODE_NORMAL;
      cur_reg     <= MODE_NORMAL;
      ready_reg   <= '0;
      done_reg    <= 1'b0;
      done_id_reg <= '0;
      err_reg     <= '0;
      id_reg      <= '0;
      wdog_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      sel_reg     <= sel_next;
      cur_reg     <= cur_next;
      ready_reg   <= ready_next;
      done_reg    <= done_next;
      done_id_reg <= done_id_next;
      err_reg     <= err_next;
      id_reg      <= id_next;
      wdog_reg    <= wdog_next;
    end
  end

  assign req_ready        = ready_reg;
  assign bias_mode_select = sel_reg;
  assign cur_mode         = cur_reg;
  assign done             = done_reg;
  assign done_id          = done_id_reg;
  assign err              = err_reg;

endmodule
